// File: rtl/riscv_test_pkg.sv
// Shared definitions for the riscv-tests end-of-test monitor: verdict FSM
// state encoding and the register indices used by the riscv-tests ABI.
package riscv_test_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        PASS    = 2'd1,
        FAIL    = 2'd2,
        TIMEOUT = 2'd3
    } test_state_e;

    // riscv-tests convention registers
    localparam logic [4:0] REG_TESTNUM = 5'd3;   // current test number
    localparam logic [4:0] REG_DONE    = 5'd26;  // test-finished flag
    localparam logic [4:0] REG_RESULT  = 5'd27;  // pass flag

    // Terminal states never leave until reset.
    function automatic logic is_terminal(input test_state_e st);
        is_terminal = (st != RUN);
    endfunction

endpackage

// File: rtl/riscv_test_monitor_sat_counter.sv
// Saturating up-counter: counts enabled cycles and sticks at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] ONE_C = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] MAX_C = {W{1'b1}};

    logic [W-1:0] cnt_r;

    // Count up while enabled, holding at the maximum value once reached.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {W{1'b0}};
        end else if (en && (cnt_r != MAX_C)) begin
            cnt_r <= cnt_r + ONE_C;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/riscv_test_monitor.sv
// End-of-test monitor for riscv-tests programs. Snoops the register-file
// write-back port, shadows x3/x26/x27 and latches a pass/fail/timeout verdict
// with a one-cycle report strobe so the verdict is printed exactly once.
module riscv_test_monitor
    import riscv_test_pkg::*;
#(
    parameter int XLEN           = 64,
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_we_i,
    input  logic [4:0]       wb_waddr_i,
    input  logic [XLEN-1:0]  wb_wdata_i,
    output logic             done_o,
    output logic             pass_o,
    output logic             fail_o,
    output logic             timeout_o,
    output logic             report_o,
    output logic [XLEN-1:0]  fail_testnum_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] wb_cnt_o
);

    localparam logic [XLEN-1:0]  ONE_C      = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]  ZERO_C     = {XLEN{1'b0}};
    localparam logic [CNT_W-1:0] TO_LAST_C  = CNT_W'(TIMEOUT_CYCLES - 1);

    test_state_e     state_r;
    test_state_e     state_nxt_s;
    logic [XLEN-1:0] sh_x3_r;
    logic [XLEN-1:0] sh_x26_r;
    logic [XLEN-1:0] sh_x27_r;
    logic [XLEN-1:0] testnum_r;
    logic            done_r;
    logic            pass_r;
    logic            fail_r;
    logic            timeout_r;
    logic            report_r;

    logic            in_run_s;
    logic            acc_s;
    logic            finish_s;
    logic            expire_s;
    logic            verdict_s;
    logic            cyc_en_s;
    logic [CNT_W-1:0] cycle_cnt_s;
    logic [CNT_W-1:0] wb_cnt_s;

    // Qualify write-back traffic: only nonzero addresses while still running.
    always_comb begin
        in_run_s = !is_terminal(state_r);
        acc_s    = in_run_s && wb_we_i && (wb_waddr_i != 5'd0);
        // sh_x26 can never hold 1 while running, so this guard only documents
        // that a latched finish flag cannot retrigger a verdict.
        finish_s = acc_s && (wb_waddr_i == REG_DONE) && (wb_wdata_i == ONE_C)
                   && (sh_x26_r != ONE_C);
        expire_s = in_run_s && (cycle_cnt_s == TO_LAST_C);
    end

    // Verdict FSM next state: the finish write outranks the timeout.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            RUN: begin
                if (finish_s) begin
                    if (sh_x27_r == ONE_C) begin
                        state_nxt_s = PASS;
                    end else begin
                        state_nxt_s = FAIL;
                    end
                end else if (expire_s) begin
                    state_nxt_s = TIMEOUT;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            PASS:    state_nxt_s = PASS;
            FAIL:    state_nxt_s = FAIL;
            TIMEOUT: state_nxt_s = TIMEOUT;
            default: state_nxt_s = RUN;
        endcase
        verdict_s = in_run_s && is_terminal(state_nxt_s);
        cyc_en_s  = in_run_s && !verdict_s;
    end

    // FSM state, registered verdict flags, report strobe and test-number capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= RUN;
            done_r    <= 1'b0;
            pass_r    <= 1'b0;
            fail_r    <= 1'b0;
            timeout_r <= 1'b0;
            report_r  <= 1'b0;
            testnum_r <= ZERO_C;
        end else begin
            state_r   <= state_nxt_s;
            done_r    <= is_terminal(state_nxt_s);
            pass_r    <= (state_nxt_s == PASS);
            fail_r    <= (state_nxt_s == FAIL);
            timeout_r <= (state_nxt_s == TIMEOUT);
            report_r  <= verdict_s;
            if (verdict_s) begin
                testnum_r <= sh_x3_r;
            end else begin
                testnum_r <= testnum_r;
            end
        end
    end

    // Shadow copies of the convention registers, frozen once a verdict exists.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_x3_r  <= ZERO_C;
            sh_x26_r <= ZERO_C;
            sh_x27_r <= ZERO_C;
        end else if (acc_s) begin
            if (wb_waddr_i == REG_TESTNUM) begin
                sh_x3_r <= wb_wdata_i;
            end else begin
                sh_x3_r <= sh_x3_r;
            end
            if (wb_waddr_i == REG_DONE) begin
                sh_x26_r <= wb_wdata_i;
            end else begin
                sh_x26_r <= sh_x26_r;
            end
            if (wb_waddr_i == REG_RESULT) begin
                sh_x27_r <= wb_wdata_i;
            end else begin
                sh_x27_r <= sh_x27_r;
            end
        end else begin
            sh_x3_r  <= sh_x3_r;
            sh_x26_r <= sh_x26_r;
            sh_x27_r <= sh_x27_r;
        end
    end

    // RUN cycles; stops advancing on the edge that enters a terminal state.
    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk (clk),
        .rst (rst),
        .en  (cyc_en_s),
        .cnt (cycle_cnt_s)
    );

    // Accepted write-backs, including the finishing x26 write itself.
    sat_counter #(.W(CNT_W)) u_wb_cnt (
        .clk (clk),
        .rst (rst),
        .en  (acc_s),
        .cnt (wb_cnt_s)
    );

    assign done_o         = done_r;
    assign pass_o         = pass_r;
    assign fail_o         = fail_r;
    assign timeout_o      = timeout_r;
    assign report_o       = report_r;
    assign fail_testnum_o = testnum_r;
    assign cycle_cnt_o    = cycle_cnt_s;
    assign wb_cnt_o       = wb_cnt_s;

endmodule
